// File: rtl/wb_io_master.sv
// Purpose: bridges one J1 CPU I/O read/write into one Wishbone classic-pipelined cycle.
// Latency: a zero-wait slave stalls the CPU for 3 cycles; each STALL or ack-wait cycle adds one.
// Backpressure: io_busy holds the CPU until ACK or timeout; wb_stall holds STB in place.
module wb_io_master #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic [AW-1:0]   io_addr,
    input  logic [DW-1:0]   io_dout,
    output logic [DW-1:0]   io_din,
    output logic            io_busy,
    output logic            io_err,
    output logic            wb_cyc,
    output logic            wb_stb,
    output logic            wb_we,
    output logic [AW-1:0]   wb_adr,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack,
    input  logic            wb_stall
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          in_bus;
    logic          ack_ok;
    logic          timeout;

    // The CPU is stalled from the request cycle until DONE, where it may advance.
    assign io_busy = (state == S_IDLE && (io_rd || io_wr)) || state == S_REQ || state == S_WAIT;
    assign wb_sel  = '1;
    assign in_bus  = (state == S_REQ) || (state == S_WAIT);

    // An ACK only counts once the strobe has been accepted (same edge in REQ is fine).
    assign ack_ok  = wb_ack && ((state == S_REQ && !wb_stall) || state == S_WAIT);
    // A real ACK on the last allowed cycle beats the timeout.
    assign timeout = in_bus && (cnt == CW'(TIMEOUT - 1)) && !ack_ok;

    // Bus cycle sequencer: launch, wait for accept/ack or timeout, one DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_dat_o <= '0;
            io_din   <= '0;
            io_err   <= 1'b0;
        end else begin
            io_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io_rd || io_wr) begin
                        wb_adr   <= io_addr;
                        wb_dat_o <= io_dout;
                        wb_we    <= io_wr;
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        cnt      <= '0;
                        state    <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (ack_ok) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        if (!wb_we) io_din <= wb_dat_i;
                        state  <= S_DONE;
                    end else if (timeout) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        if (!wb_we) io_din <= '1;
                        io_err <= 1'b1;
                        state  <= S_DONE;
                    end else if (state == S_REQ && !wb_stall) begin
                        wb_stb <= 1'b0;
                        state  <= S_WAIT;
                    end
                end
                // The CPU's request lines still belong to the finished access here.
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_io_master.md
Name: wb_io_master

Overview:
- Wishbone master bridge between the J1 CPU I/O port and the I/O bus; its bus side drives the I/O slave.
- Converts a single-cycle CPU I/O read/write request into one Wishbone classic pipelined cycle.
- Stalls the CPU until the cycle finishes, then returns read data.
- Includes a bus timeout so an unresponsive slave cannot hang the CPU.

Parameters:
- AW, 16, address width of io_addr / wb_adr
- DW, 16, data width
- TIMEOUT, 255, cycles in REQ+WAIT before the cycle is aborted; must be ≥ 2

Ports:
- clk  in  1  system clock; sole clock
- rst_n  in  1  reset, asynchronous assert, active-low
- io_rd  in  1  CPU I/O read request; held while io_busy=1
- io_wr  in  1  CPU I/O write request; held while io_busy=1
- io_addr  in  AW  CPU I/O address
- io_dout  in  DW  CPU write data
- io_din  out  DW  read data to CPU
- io_busy  out  1  CPU stall
- io_err  out  1  one-cycle pulse on timeout abort
- wb_cyc  out  1  Wishbone CYC
- wb_stb  out  1  Wishbone STB
- wb_we  out  1  Wishbone WE
- wb_adr  out  AW  Wishbone ADR
- wb_dat_o  out  DW  Wishbone master write data
- wb_sel  out  DW/8  byte selects; constant all ones
- wb_dat_i  in  DW  Wishbone read data
- wb_ack  in  1  Wishbone ACK
- wb_stall  in  1  Wishbone STALL

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - wb_cyc, wb_stb, wb_we, io_err = 0.
  - wb_adr, wb_dat_o, io_din = 0.
  - Counter = 0.
  - Reset mid-cycle drops CYC/STB immediately; the CPU request is lost.
- All Wishbone outputs and io_din are registered.
- io_busy is combinational: io_busy = (state==IDLE & (io_rd|io_wr)) | state==REQ | state==WAIT.
- IDLE:
  - On io_rd|io_wr, capture io_addr→wb_adr and io_dout→wb_dat_o.
  - Set wb_we = io_wr; if io_rd and io_wr are both high, the write wins.
  - Set wb_cyc=wb_stb=1, clear counter, go to REQ.
- REQ:
  - wb_stb held while wb_stall=1.
  - At an edge with wb_stall=0, the request is accepted: wb_stb←0, go to WAIT.
  - If wb_ack is also 1 at that edge, go directly to DONE.
- WAIT:
  - wb_cyc=1, wb_stb=0.
  - At an edge with wb_ack=1: wb_cyc←0, go to DONE.
  - If wb_we=0, io_din←wb_dat_i at that edge.
- DONE:
  - Lasts one cycle; io_busy=0, so the CPU advances at the end of this cycle.
  - io_rd/io_wr are ignored here (they still belong to the finished instruction).
  - Next state: IDLE.
- Timeout:
  - Counter increments every cycle in REQ or WAIT.
  - When counter==TIMEOUT-1 and no ack arrives at that edge: wb_cyc←wb_stb←0.
  - On a read, io_din←all ones.
  - io_err←1 for the DONE cycle; go to DONE.
  - An ack at the same edge as the timeout wins (normal completion, no error).
- wb_ack outside REQ/WAIT is ignored.
- io_din holds its value until the next read completion or timeout.
- Latency with a zero-wait, non-stalling slave:
  - cycle0: request, IDLE.
  - cycle1: STB.
  - cycle2: ACK seen.
  - cycle3: DONE with io_busy=0.
  - The CPU is therefore stalled for cycles 0–2.
  - Each wb_stall cycle adds one; each ack wait cycle adds one.
- Back-to-back requests: DONE→IDLE→new request; minimum 4 cycles per access.
- Exactly one STB-accepted transfer per CYC; no pipelining of multiple requests.

Test Plan:
1. Write, zero-wait slave: io_wr=1, io_addr=16'h0004, io_dout=16'hBEEF → cycle1 has cyc=stb=we=1, adr=0004, dat_o=BEEF; ack in cycle2; io_busy low in cycle3; exactly one STB cycle.
2. Read, zero-wait slave returning 16'h1234 → io_din=1234 in cycle3 with io_busy=0; wb_we=0 throughout.
3. Stall: slave holds wb_stall=1 for 3 cycles on a read → stb stays high 4 cycles, then ack; io_busy high for 6 cycles; adr stable throughout.
4. Timeout, TIMEOUT=8, slave never acks a read → cyc drops after 8 cycles in REQ/WAIT; io_err pulses once; io_din=16'hFFFF; next request proceeds normally.
5. Simultaneous io_rd=io_wr=1 → write cycle (we=1); io_din unchanged. Back-to-back reads → second STB four cycles after the first.
6. rst_n driven low while in WAIT → cyc/stb/io_busy fall asynchronously within the same cycle; after release, the bridge is IDLE and accepts a new write.
